// File: rtl/seven_seg_scan_decoder_if.sv
// Bundle of the scanned 7-segment inputs and the reconstructed frame outputs.
// The decoder takes the slave side; whoever drives the scan takes the master side.
interface seven_seg_scan_decoder_if;
    logic [0:6]  segment;
    logic [0:3]  anode;
    logic [0:15] digits;
    logic [0:3]  blank;
    logic        seg_error;
    logic        frame_valid;
    logic        scan_stall;

    modport master (
        output segment, anode,
        input  digits, blank, seg_error, frame_valid, scan_stall
    );

    modport slave (
        input  segment, anode,
        output digits, blank, seg_error, frame_valid, scan_stall
    );
endinterface

// File: rtl/seven_seg_scan_decoder.sv
// Rebuilds a stable 4-digit frame from a multiplexed common-anode 7-segment scan.
// Each digit must be seen unchanged for SETTLE_CYCLES samples before it is accepted.
module seven_seg_scan_decoder #(
    parameter int unsigned SETTLE_CYCLES  = 16,
    parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
    input logic                     i_clk,
    input logic                     i_reset_n,
    seven_seg_scan_decoder_if.slave bus
);

    localparam int unsigned CNT_W = $clog2(SETTLE_CYCLES + 1);
    localparam int unsigned TMO_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [TMO_W-1:0] TMO_MAX     = TMO_W'(TIMEOUT_CYCLES);

    typedef enum logic [1:0] {StIdle, StSettle, StHold} state_e;

    // {blank, error, code}
    function automatic logic [5:0] f_decode(input logic [0:6] seg);
        case (seg)
            7'b0000001: return {2'b00, 4'h0};
            7'b1001111: return {2'b00, 4'h1};
            7'b0010010: return {2'b00, 4'h2};
            7'b0000110: return {2'b00, 4'h3};
            7'b1001100: return {2'b00, 4'h4};
            7'b0100100: return {2'b00, 4'h5};
            7'b0100000: return {2'b00, 4'h6};
            7'b0001111: return {2'b00, 4'h7};
            7'b0000000: return {2'b00, 4'h8};
            7'b0000100: return {2'b00, 4'h9};
            7'b1111111: return {2'b10, 4'hF};
            default:    return {2'b01, 4'hE};
        endcase
    endfunction

    logic [0:6]       r_seg_meta, r_seg_sync, r_lat_seg;
    logic [0:3]       r_an_meta, r_an_sync, r_lat_an;
    state_e           r_state;
    logic [CNT_W-1:0] r_stable_cnt;
    logic [0:15]      r_shadow, r_digits;
    logic [0:3]       r_sh_blank, r_blank, r_mask;
    logic             r_seg_error, r_frame_valid;
    logic [TMO_W-1:0] r_timeout;

    logic             w_sel_valid, w_same, w_accept;
    logic [1:0]       w_sel_idx;
    logic [5:0]       w_dec;
    logic [0:3]       w_mask_next;

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_seg_meta <= '1;
            r_seg_sync <= '1;
            r_an_meta  <= '1;
            r_an_sync  <= '1;
        end else begin
            r_seg_meta <= bus.segment;
            r_seg_sync <= r_seg_meta;
            r_an_meta  <= bus.anode;
            r_an_sync  <= r_an_meta;
        end
    end

    // Exactly one low anode is a real digit; anything else is a gap.
    always_comb begin
        w_sel_valid = 1'b1;
        w_sel_idx   = 2'd0;
        case (r_an_sync)
            4'b0111: w_sel_idx = 2'd0;
            4'b1011: w_sel_idx = 2'd1;
            4'b1101: w_sel_idx = 2'd2;
            4'b1110: w_sel_idx = 2'd3;
            default: w_sel_valid = 1'b0;
        endcase
    end

    assign w_same   = (r_an_sync == r_lat_an) && (r_seg_sync == r_lat_seg);
    assign w_accept = (r_state == StSettle) && w_same && (r_stable_cnt == SETTLE_LAST);
    assign w_dec    = f_decode(r_lat_seg);

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_state      <= StIdle;
            r_lat_an     <= '1;
            r_lat_seg    <= '1;
            r_stable_cnt <= '0;
        end else begin
            case (r_state)
                StIdle: begin
                    if (w_sel_valid) begin
                        r_lat_an     <= r_an_sync;
                        r_lat_seg    <= r_seg_sync;
                        r_stable_cnt <= CNT_W'(1);
                        r_state      <= StSettle;
                    end
                end
                StSettle: begin
                    if (w_same) begin
                        r_stable_cnt <= r_stable_cnt + 1'b1;
                        if (r_stable_cnt == SETTLE_LAST) r_state <= StHold;
                    end else if (w_sel_valid) begin
                        r_lat_an     <= r_an_sync;
                        r_lat_seg    <= r_seg_sync;
                        r_stable_cnt <= CNT_W'(1);
                    end else begin
                        r_state <= StIdle;
                    end
                end
                StHold: begin
                    // Leaving only on a change stops the same scan slot being accepted twice.
                    if (!w_same) r_state <= StIdle;
                end
                default: r_state <= StIdle;
            endcase
        end
    end

    // A publish clears the mask, but an accept in that same cycle still lands in it.
    always_comb begin
        w_mask_next = (r_mask == 4'b1111) ? 4'b0000 : r_mask;
        if (w_accept) w_mask_next[w_sel_idx] = 1'b1;
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_shadow      <= '1;
            r_sh_blank    <= '1;
            r_mask        <= '0;
            r_digits      <= '1;
            r_blank       <= '1;
            r_frame_valid <= 1'b0;
            r_seg_error   <= 1'b0;
            r_timeout     <= '0;
        end else begin
            r_mask        <= w_mask_next;
            r_frame_valid <= 1'b0;
            if (r_mask == 4'b1111) begin
                r_digits      <= r_shadow;
                r_blank       <= r_sh_blank;
                r_frame_valid <= 1'b1;
            end
            if (w_accept) begin
                r_shadow[{w_sel_idx, 2'b00} +: 4] <= w_dec[3:0];
                r_sh_blank[w_sel_idx]             <= w_dec[5];
                r_seg_error                       <= r_seg_error | w_dec[4];
                r_timeout                         <= '0;
            end else if (r_timeout != TMO_MAX) begin
                r_timeout <= r_timeout + 1'b1;
            end
        end
    end

    assign bus.digits      = r_digits;
    assign bus.blank       = r_blank;
    assign bus.seg_error   = r_seg_error;
    assign bus.frame_valid = r_frame_valid;
    assign bus.scan_stall  = (r_timeout == TMO_MAX);

endmodule

// File: tb/tb_seven_seg_scan_decoder.sv
// Self-checking bench: scans digit patterns into the decoder and scoreboards published frames.
module tb_seven_seg_scan_decoder;

    localparam int unsigned SETTLE = 16;
    localparam int unsigned TMO    = 200;

    typedef struct packed {
        logic [15:0] d;
        logic [3:0]  b;
    } frame_t;

    logic   clk     = 1'b0;
    logic   reset_n = 1'b1;
    int     tests_run    = 0;
    int     tests_failed = 0;
    frame_t exp_q[$];

    always #5 clk = ~clk;

    seven_seg_scan_decoder_if u_bus ();

    seven_seg_scan_decoder #(
        .SETTLE_CYCLES (SETTLE),
        .TIMEOUT_CYCLES(TMO)
    ) u_dut (
        .i_clk    (clk),
        .i_reset_n(reset_n),
        .bus      (u_bus)
    );

    function automatic logic [6:0] seg_of(input int v);
        case (v)
            0:       return 7'b0000001;
            1:       return 7'b1001111;
            2:       return 7'b0010010;
            3:       return 7'b0000110;
            4:       return 7'b1001100;
            5:       return 7'b0100100;
            6:       return 7'b0100000;
            7:       return 7'b0001111;
            8:       return 7'b0000000;
            9:       return 7'b0000100;
            default: return 7'b1111111;
        endcase
    endfunction

    function automatic logic [3:0] sel_of(input int idx);
        logic [3:0] a;
        a = 4'b1111;
        a[3-idx] = 1'b0;
        return a;
    endfunction

    task automatic drive(input logic [3:0] an, input logic [6:0] seg, input int n);
        u_bus.anode   = an;
        u_bus.segment = seg;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic scan(input logic [6:0] s0, input logic [6:0] s1, input logic [6:0] s2,
                        input logic [6:0] s3, input int gap);
        drive(sel_of(0), s0, 100);
        if (gap > 0) drive(4'b1111, 7'h7F, gap);
        drive(sel_of(1), s1, 100);
        if (gap > 0) drive(4'b1111, 7'h7F, gap);
        drive(sel_of(2), s2, 100);
        if (gap > 0) drive(4'b1111, 7'h7F, gap);
        drive(sel_of(3), s3, 100);
    endtask

    // Scoreboard: every frame_valid pulse must match the oldest expected frame.
    always @(negedge clk) begin
        if (reset_n && u_bus.frame_valid === 1'b1) begin
            tests_run = tests_run + 1;
            if (exp_q.size() == 0) begin
                tests_failed = tests_failed + 1;
                $display("FAIL frame_unexpected: got digits=%h blank=%b, expected no frame",
                         u_bus.digits, u_bus.blank);
            end else begin
                frame_t e;
                e = exp_q.pop_front();
                if (u_bus.digits !== e.d || u_bus.blank !== e.b) begin
                    tests_failed = tests_failed + 1;
                    $display("FAIL frame_content: got digits=%h blank=%b, expected digits=%h blank=%b",
                             u_bus.digits, u_bus.blank, e.d, e.b);
                end
            end
        end
    end

    task automatic test_reset();
        u_bus.anode   = 4'b1111;
        u_bus.segment = 7'h7F;
        #2 reset_n = 1'b0;
        #1;
        tests_run = tests_run + 5;
        if (u_bus.digits !== 16'hFFFF) begin
            tests_failed++; $display("FAIL reset_digits: got %h, expected ffff", u_bus.digits);
        end
        if (u_bus.blank !== 4'b1111) begin
            tests_failed++; $display("FAIL reset_blank: got %b, expected 1111", u_bus.blank);
        end
        if (u_bus.seg_error !== 1'b0) begin
            tests_failed++; $display("FAIL reset_seg_error: got %b, expected 0", u_bus.seg_error);
        end
        if (u_bus.frame_valid !== 1'b0) begin
            tests_failed++; $display("FAIL reset_frame_valid: got %b, expected 0", u_bus.frame_valid);
        end
        if (u_bus.scan_stall !== 1'b0) begin
            tests_failed++; $display("FAIL reset_scan_stall: got %b, expected 0", u_bus.scan_stall);
        end
        repeat (3) @(posedge clk);
        #1 reset_n = 1'b1;
        drive(4'b1111, 7'h7F, 10);
        tests_run = tests_run + 2;
        if (u_bus.digits !== 16'hFFFF || u_bus.blank !== 4'b1111) begin
            tests_failed++;
            $display("FAIL idle_after_reset: got digits=%h blank=%b, expected ffff 1111",
                     u_bus.digits, u_bus.blank);
        end
        if (u_bus.scan_stall !== 1'b0) begin
            tests_failed++; $display("FAIL idle_stall: got %b, expected 0", u_bus.scan_stall);
        end
    endtask

    task automatic test_scan_1234();
        exp_q.push_back('{d: 16'h1234, b: 4'b0000});
        exp_q.push_back('{d: 16'h1234, b: 4'b0000});
        scan(seg_of(1), seg_of(2), seg_of(3), seg_of(4), 0);
        scan(seg_of(1), seg_of(2), seg_of(3), seg_of(4), 0);
        drive(4'b1111, 7'h7F, 20);
        tests_run = tests_run + 2;
        if (exp_q.size() != 0) begin
            tests_failed++; $display("FAIL scan_frames_missing: %0d left, expected 0", exp_q.size());
        end
        if (u_bus.seg_error !== 1'b0) begin
            tests_failed++; $display("FAIL scan_seg_error: got %b, expected 0", u_bus.seg_error);
        end
    endtask

    // Slot 0 completes the frame, so a premature accept of "8" would be published.
    task automatic test_glitch();
        exp_q.push_back('{d: 16'h5234, b: 4'b0000});
        drive(sel_of(1), seg_of(2), 100);
        drive(sel_of(2), seg_of(3), 100);
        drive(sel_of(3), seg_of(4), 100);
        drive(4'b1111, 7'h7F, 3);
        drive(sel_of(0), seg_of(8), SETTLE - 1);
        drive(sel_of(0), seg_of(5), 100);
        drive(4'b1111, 7'h7F, 20);
        tests_run = tests_run + 2;
        if (exp_q.size() != 0) begin
            tests_failed++; $display("FAIL glitch_frame_missing: %0d left, expected 0", exp_q.size());
        end
        if (u_bus.digits !== 16'h5234) begin
            tests_failed++; $display("FAIL glitch_digits: got %h, expected 5234", u_bus.digits);
        end
    endtask

    task automatic test_gap_overlap();
        exp_q.push_back('{d: 16'h1234, b: 4'b0000});
        drive(sel_of(0), seg_of(1), 100);
        drive(4'b1111, 7'h7F, 3);
        drive(sel_of(1), seg_of(2), 100);
        drive(4'b1100, seg_of(8), 20);
        drive(sel_of(2), seg_of(3), 100);
        drive(4'b1111, 7'h7F, 3);
        drive(sel_of(3), seg_of(4), 100);
        drive(4'b1111, 7'h7F, 20);
        tests_run = tests_run + 1;
        if (exp_q.size() != 0) begin
            tests_failed++; $display("FAIL gap_frame_missing: %0d left, expected 0", exp_q.size());
        end
    endtask

    task automatic test_blank_error();
        exp_q.push_back('{d: 16'h12FE, b: 4'b0010});
        scan(seg_of(1), seg_of(2), 7'b1111111, 7'b1111110, 3);
        drive(4'b1111, 7'h7F, 20);
        tests_run = tests_run + 2;
        if (u_bus.seg_error !== 1'b1) begin
            tests_failed++; $display("FAIL error_set: got %b, expected 1", u_bus.seg_error);
        end
        if (exp_q.size() != 0) begin
            tests_failed++; $display("FAIL blank_frame_missing: %0d left, expected 0", exp_q.size());
        end
        exp_q.push_back('{d: 16'h1234, b: 4'b0000});
        scan(seg_of(1), seg_of(2), seg_of(3), seg_of(4), 3);
        drive(4'b1111, 7'h7F, 20);
        tests_run = tests_run + 2;
        if (u_bus.seg_error !== 1'b1) begin
            tests_failed++; $display("FAIL error_sticky: got %b, expected 1", u_bus.seg_error);
        end
        if (exp_q.size() != 0) begin
            tests_failed++; $display("FAIL sticky_frame_missing: %0d left, expected 0", exp_q.size());
        end
    endtask

    // Last accept lands SETTLE+2 edges after the digit is driven (2 sync stages).
    task automatic test_stall();
        int first_high = -1;
        int first_low  = -1;
        exp_q.push_back('{d: 16'h1234, b: 4'b0000});
        drive(sel_of(0), seg_of(1), 100);
        drive(sel_of(1), seg_of(2), 100);
        drive(sel_of(2), seg_of(3), 100);
        drive(4'b1111, 7'h7F, 3);
        u_bus.anode   = sel_of(3);
        u_bus.segment = seg_of(4);
        for (int n = 1; n <= 260; n++) begin
            @(posedge clk);
            #1;
            if (n == 100) begin
                u_bus.anode   = 4'b1111;
                u_bus.segment = 7'h7F;
            end
            if (first_high < 0 && u_bus.scan_stall === 1'b1) first_high = n;
        end
        tests_run = tests_run + 3;
        if (first_high != int'(SETTLE + 2 + TMO)) begin
            tests_failed++;
            $display("FAIL stall_rise: got edge %0d, expected %0d", first_high, SETTLE + 2 + TMO);
        end
        if (u_bus.digits !== 16'h1234 || u_bus.blank !== 4'b0000) begin
            tests_failed++;
            $display("FAIL stall_hold: got digits=%h blank=%b, expected 1234 0000",
                     u_bus.digits, u_bus.blank);
        end
        if (exp_q.size() != 0) begin
            tests_failed++; $display("FAIL stall_frame_missing: %0d left, expected 0", exp_q.size());
        end
        exp_q.push_back('{d: 16'h1234, b: 4'b0000});
        u_bus.anode   = sel_of(0);
        u_bus.segment = seg_of(1);
        for (int n = 1; n <= 100; n++) begin
            @(posedge clk);
            #1;
            if (first_low < 0 && u_bus.scan_stall === 1'b0) first_low = n;
        end
        tests_run = tests_run + 1;
        if (first_low != int'(SETTLE + 2)) begin
            tests_failed++;
            $display("FAIL stall_fall: got edge %0d, expected %0d", first_low, SETTLE + 2);
        end
        drive(sel_of(1), seg_of(2), 100);
        drive(sel_of(2), seg_of(3), 100);
        drive(sel_of(3), seg_of(4), 100);
        drive(4'b1111, 7'h7F, 20);
        tests_run = tests_run + 1;
        if (exp_q.size() != 0) begin
            tests_failed++; $display("FAIL resume_frame_missing: %0d left, expected 0", exp_q.size());
        end
    endtask

    task automatic test_reset_mid_frame();
        drive(sel_of(0), seg_of(1), 100);
        drive(sel_of(1), seg_of(2), 100);
        #2 reset_n = 1'b0;
        #1;
        tests_run = tests_run + 3;
        if (u_bus.digits !== 16'hFFFF || u_bus.blank !== 4'b1111) begin
            tests_failed++;
            $display("FAIL midreset_outputs: got digits=%h blank=%b, expected ffff 1111",
                     u_bus.digits, u_bus.blank);
        end
        if (u_bus.seg_error !== 1'b0) begin
            tests_failed++; $display("FAIL midreset_seg_error: got %b, expected 0", u_bus.seg_error);
        end
        if (u_bus.scan_stall !== 1'b0 || u_bus.frame_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL midreset_flags: got stall=%b fv=%b, expected 0 0",
                     u_bus.scan_stall, u_bus.frame_valid);
        end
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
        drive(4'b1111, 7'h7F, 3);
        drive(sel_of(2), seg_of(3), 100);
        drive(sel_of(3), seg_of(4), 100);
        drive(4'b1111, 7'h7F, 30);
        tests_run = tests_run + 1;
        if (u_bus.digits !== 16'hFFFF) begin
            tests_failed++; $display("FAIL midreset_partial: got %h, expected ffff", u_bus.digits);
        end
        exp_q.push_back('{d: 16'h7834, b: 4'b0000});
        drive(sel_of(0), seg_of(7), 100);
        drive(sel_of(1), seg_of(8), 100);
        drive(4'b1111, 7'h7F, 20);
        tests_run = tests_run + 2;
        if (exp_q.size() != 0) begin
            tests_failed++; $display("FAIL midreset_frame_missing: %0d left, expected 0", exp_q.size());
        end
        if (u_bus.digits !== 16'h7834) begin
            tests_failed++; $display("FAIL midreset_new_frame: got %h, expected 7834", u_bus.digits);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_scan_1234();
        test_glitch();
        test_gap_overlap();
        test_blank_error();
        test_stall();
        test_reset_mid_frame();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
